// File: rtl/sram_controller_pkg.sv
// Shared definitions for the data-memory SRAM controller.
// No logic; types and constants only.
// Imported by the controller top and its wait counter.
package sram_controller_pkg;

    // FSM encoding is fixed so the state can be probed and decoded externally.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Byte address that maps onto SRAM word 0.
    localparam int BASE_ADDR_DEFAULT = 1024;

    // Width of the external SRAM data bus (one half of a core word).
    localparam int SRAM_DW = 16;

    // Wait-counter width: holds WAIT_CYCLES-1 for WAIT_CYCLES up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times each SRAM half-access.
// Latency: load/decrement visible one cycle later; o_tc is combinational from the count.
// No backpressure; the controller decides when to load or count.
module sram_wait_counter
    import sram_controller_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // Load has priority over counting; the count parks at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/sram_controller.sv
// Executes one 32-bit core load/store as two 16-bit accesses on an async SRAM.
// Latency: ready rises 2*WAIT_CYCLES+1 cycles after the request first appears.
// Backpressure: ready is held low while a request is pending; flushed requests finish silently.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = BASE_ADDR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DW-1:0]     sram_dq_out,
    input  logic [SRAM_DW-1:0]     sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam int                WORD_W   = SRAM_ADDR_W - 1;
    localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    // Registered state
    state_t                   r_state;
    logic                     r_is_wr;
    logic [WORD_W-1:0]        r_word;
    logic [31:0]              r_wdata;
    logic                     r_abandon;
    logic [SRAM_ADDR_W-1:0]   r_sram_addr;
    logic [SRAM_DW-1:0]       r_dq_out;
    logic                     r_dq_oe;
    logic                     r_we_n;
    logic [31:0]              r_rdata;

    // Combinational next values
    state_t                   w_state_next;
    logic                     w_req;
    logic                     w_latch;
    logic                     w_cnt_load;
    logic                     w_cnt_en;
    logic                     w_cnt_tc;
    logic                     w_abandon_next;
    logic [SRAM_ADDR_W-1:0]   w_addr_next;
    logic [SRAM_DW-1:0]       w_dq_out_next;
    logic                     w_dq_oe_next;
    logic                     w_we_n_next;
    logic                     w_cap_lo;
    logic                     w_cap_hi;

    // Address translation: word index wraps modulo the SRAM size, no range check.
    logic [31:0]              w_offset;
    logic [WORD_W-1:0]        w_word_in;
    logic                     w_unused;

    assign w_req     = wr_en | rd_en;
    assign w_offset  = address - 32'(BASE_ADDR);
    assign w_word_in = w_offset[SRAM_ADDR_W:2];
    assign w_unused  = ^{w_offset[31:SRAM_ADDR_W+1], w_offset[1:0]};

    sram_wait_counter #(
        .W (CNT_W)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (LOAD_VAL),
        .i_en       (w_cnt_en),
        .o_tc       (w_cnt_tc)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and next values for the registered SRAM pins
    always_comb begin
        w_state_next   = r_state;
        w_latch        = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_en       = 1'b0;
        w_abandon_next = r_abandon;
        w_addr_next    = r_sram_addr;
        w_dq_out_next  = '0;
        w_dq_oe_next   = 1'b0;
        w_we_n_next    = 1'b1;
        w_cap_lo       = 1'b0;
        w_cap_hi       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    // Writes win when both enables are high.
                    w_latch      = 1'b1;
                    w_cnt_load   = 1'b1;
                    w_state_next = ST_LOW;
                    w_addr_next  = {w_word_in, 1'b0};
                    if (wr_en) begin
                        w_dq_out_next = wdata[15:0];
                        w_dq_oe_next  = 1'b1;
                        w_we_n_next   = 1'b0;
                    end
                end
            end

            ST_LOW: begin
                if (!w_req) begin
                    w_abandon_next = 1'b1;
                end
                if (w_cnt_tc) begin
                    w_cap_lo     = ~r_is_wr;
                    w_cnt_load   = 1'b1;
                    w_state_next = ST_HIGH;
                    w_addr_next  = {r_word, 1'b1};
                    if (r_is_wr) begin
                        w_dq_out_next = r_wdata[31:16];
                        w_dq_oe_next  = 1'b1;
                        w_we_n_next   = 1'b0;
                    end
                end else begin
                    w_cnt_en      = 1'b1;
                    w_dq_out_next = r_dq_out;
                    w_dq_oe_next  = r_is_wr;
                    w_we_n_next   = ~r_is_wr;
                end
            end

            ST_HIGH: begin
                if (!w_req) begin
                    w_abandon_next = 1'b1;
                end
                if (w_cnt_tc) begin
                    // Strobe and drive are released on the way into DONE.
                    w_cap_hi     = ~r_is_wr;
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_en      = 1'b1;
                    w_dq_out_next = r_dq_out;
                    w_dq_oe_next  = r_is_wr;
                    w_we_n_next   = ~r_is_wr;
                end
            end

            ST_DONE: begin
                w_abandon_next = 1'b0;
                w_state_next   = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch: op, word and store data are frozen for the whole access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_wr <= 1'b0;
            r_word  <= '0;
            r_wdata <= '0;
        end else if (w_latch) begin
            r_is_wr <= wr_en;
            r_word  <= w_word_in;
            r_wdata <= wdata;
        end
    end

    // Registered SRAM pins and flush tracking; reset releases the bus at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
            r_abandon   <= 1'b0;
        end else begin
            r_sram_addr <= w_addr_next;
            r_dq_out    <= w_dq_out_next;
            r_dq_oe     <= w_dq_oe_next;
            r_we_n      <= w_we_n_next;
            r_abandon   <= w_abandon_next;
        end
    end

    // Load data capture on the last cycle of each read half; held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else begin
            if (w_cap_lo) begin
                r_rdata[15:0] <= sram_dq_in;
            end
            if (w_cap_hi) begin
                r_rdata[31:16] <= sram_dq_in;
            end
        end
    end

    // A flushed access reaching DONE must not acknowledge a newer request.
    assign ready       = ~w_req | ((r_state == ST_DONE) & ~r_abandon);
    assign rdata       = r_rdata;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural SRAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Every op is a fixed-length cycle sequence, so the run always terminates.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [0:15];

    sram_controller dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: asynchronous read, write while we_n is low.
    assign sram_dq_in = mem[sram_addr[3:0]];
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[3:0]] <= sram_dq_out;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete request held for cycles 0..7; the enables drop at the start of cycle 8.
    task automatic run_op(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [17:0] lo,
                          input logic chk_rd, input logic [31:0] exp_rd);
        logic [17:0] ea;
        logic [15:0] ed;
        logic        phase;
        wr_en = w;
        rd_en = r;
        address = a;
        wdata = d;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq($sformatf("ready_c%0d", c), 32'(ready), (c == 7) ? 32'd1 : 32'd0);
            phase = (c >= 1) && (c <= 6);
            if (phase) begin
                ea = (c <= 3) ? lo : (lo | 18'd1);
                ed = (c <= 3) ? d[15:0] : d[31:16];
                check_eq($sformatf("addr_c%0d", c), 32'(sram_addr), 32'(ea));
                check_eq($sformatf("we_n_c%0d", c), 32'(sram_we_n), w ? 32'd0 : 32'd1);
                check_eq($sformatf("oe_c%0d", c), 32'(sram_dq_oe), w ? 32'd1 : 32'd0);
                if (w) check_eq($sformatf("dq_c%0d", c), 32'(sram_dq_out), 32'(ed));
            end else begin
                check_eq($sformatf("we_n_idle_c%0d", c), 32'(sram_we_n), 32'd1);
                check_eq($sformatf("oe_idle_c%0d", c), 32'(sram_dq_oe), 32'd0);
            end
            if (c == 7 && chk_rd) check_eq("rdata_done", rdata, exp_rd);
            next_cycle();
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;

        // Reset state
        #12;
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_addr", 32'(sram_addr), 32'h0);
        check_eq("rst_dq", 32'(sram_dq_out), 32'h0);
        check_eq("rst_oe", 32'(sram_dq_oe), 32'h0);
        check_eq("rst_we_n", 32'(sram_we_n), 32'h1);
        check_eq("rst_state", 32'(dut.r_state), 32'h0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", 32'(ready), 32'h1);
        next_cycle();

        // Plain write then read-back of word 0
        run_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0, 1'b1, 32'h0);
        check_eq("mem0_lo", 32'(mem[0]), 32'h0000BEEF);
        check_eq("mem1_hi", 32'(mem[1]), 32'h0000DEAD);
        run_op(1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 1'b1, 32'hDEADBEEF);

        // Both enables high: write wins; word 2^17 wraps onto SRAM address 0
        run_op(1'b1, 1'b1, 32'd1024 + 32'd524288, 32'h12345678, 18'd0, 1'b1, 32'hDEADBEEF);
        run_op(1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 1'b1, 32'h12345678);

        // Flush: write to word 2 dropped in cycle 2, read arrives in cycle 5
        wr_en = 1'b1; address = 32'd1032; wdata = 32'hCAFEF00D;
        for (int c = 0; c < 16; c++) begin
            if (c == 2) wr_en = 1'b0;
            if (c == 5) begin
                rd_en = 1'b1;
                address = 32'd1024;
            end
            @(negedge clk);
            check_eq($sformatf("fl_ready_c%0d", c), 32'(ready),
                     ((c >= 2 && c <= 4) || c == 15) ? 32'd1 : 32'd0);
            if (c == 2) check_eq("fl_addr_c2", 32'(sram_addr), 32'd4);
            if (c == 6) begin
                check_eq("fl_addr_c6", 32'(sram_addr), 32'd5);
                check_eq("fl_dq_c6", 32'(sram_dq_out), 32'h0000CAFE);
                check_eq("fl_we_n_c6", 32'(sram_we_n), 32'd0);
            end
            if (c == 7) check_eq("fl_we_n_c7", 32'(sram_we_n), 32'd1);
            if (c == 15) check_eq("fl_rdata", rdata, 32'h12345678);
            next_cycle();
        end
        rd_en = 1'b0;
        check_eq("fl_mem4", 32'(mem[4]), 32'h0000F00D);
        check_eq("fl_mem5", 32'(mem[5]), 32'h0000CAFE);

        // Reset in cycle 4 of a write to word 3
        wr_en = 1'b1; address = 32'd1036; wdata = 32'h11112222;
        for (int c = 0; c < 4; c++) next_cycle();
        check_eq("mr_we_n_before", 32'(sram_we_n), 32'd0);
        check_eq("mr_addr_before", 32'(sram_addr), 32'd7);
        rst = 1'b0;
        #1;
        check_eq("mr_we_n", 32'(sram_we_n), 32'd1);
        check_eq("mr_oe", 32'(sram_dq_oe), 32'd0);
        check_eq("mr_state", 32'(dut.r_state), 32'd0);
        check_eq("mr_addr", 32'(sram_addr), 32'd0);
        check_eq("mr_rdata", rdata, 32'd0);
        wr_en = 1'b0;
        #1;
        check_eq("mr_ready", 32'(ready), 32'd1);
        next_cycle();
        rst = 1'b1;
        run_op(1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 1'b1, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
